// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - multi-cycle W=N*K add/sub that reuses one N-bit carry-select slice
// The carry passes between slices only through carry_q, so the combinational depth is one slice.

module carry_select_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         of
);
  generate
    if (N == 1) begin : g_bit
      assign {cout, s} = {1'b0, a} + {1'b0, b} + {1'b0, cin};
    end else begin : g_sel
      localparam int L = N / 2;
      localparam int H = N - L;
      logic [L:0] lo;
      logic [H:0] hi0;
      logic [H:0] hi1;
      // Both upper-half candidates are computed up front; the low-half carry picks one.
      assign lo  = {1'b0, a[L-1:0]} + {1'b0, b[L-1:0]} + {{L{1'b0}}, cin};
      assign hi0 = {1'b0, a[N-1:L]} + {1'b0, b[N-1:L]};
      assign hi1 = {1'b0, a[N-1:L]} + {1'b0, b[N-1:L]} + {{H{1'b0}}, 1'b1};
      assign {cout, s} = lo[L] ? {hi1, lo[L-1:0]} : {hi0, lo[L-1:0]};
    end
  endgenerate

  assign of = (a[N-1] ~^ b[N-1]) & (s[N-1] ^ a[N-1]);
endmodule

module wide_add_sequencer #(
  parameter int N = 32,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sub,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic           cin,
  output logic           busy,
  output logic           done,
  output logic [N*K-1:0] sum,
  output logic           cout,
  output logic           of
);
  localparam int W  = N * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_d;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_q, b_q;
  logic          sub_q, carry_q;
  logic          accept;
  logic [N-1:0]  slice_a, slice_b, slice_s;
  logic          slice_c, slice_of;

  assign slice_a = a_q[idx*N +: N];
  assign slice_b = b_q[idx*N +: N] ^ {N{sub_q}};

  carry_select_adder #(.N(N)) u_adder (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_c),
    .of   (slice_of)
  );

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (idx == LAST) state_d = DONE;
      end
      DONE: begin
        accept  = start;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      of      <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        sub_q   <= sub;
        carry_q <= sub ? 1'b1 : cin;
        idx     <= '0;
      end else if (state == RUN) begin
        sum[idx*N +: N] <= slice_s;
        carry_q         <= slice_c;
        // Only the top slice's carry and overflow describe the full-width result.
        if (idx == LAST) begin
          cout <= slice_c;
          of   <= slice_of;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - scoreboard bench for wide_add_sequencer with N=8, K=4
module tb_wide_add_sequencer;
  localparam int N = 8;
  localparam int K = 4;
  localparam int W = N * K;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, of;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [W+1:0] sb[$];

  wide_add_sequencer #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .of(of)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain W+1 bit arithmetic; result packed as {of, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                         input logic ts, input logic tc);
    logic [W-1:0] eb;
    logic [W:0]   r;
    logic         ovf;
    eb  = ts ? ~tb_ : tb_;
    r   = {1'b0, ta} + {1'b0, eb} + {{W{1'b0}}, (ts ? 1'b1 : tc)};
    ovf = (ta[W-1] == eb[W-1]) && (r[W-1] != ta[W-1]);
    return {ovf, r[W], r[W-1:0]};
  endfunction

  always @(negedge clk) begin
    if (busy && done) begin
      n_bad++;
      $display("FAIL busy_and_done: got busy=%0b done=%0b", busy, done);
    end
    if (done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done with empty scoreboard");
      end else begin
        logic [W+1:0] e;
        e = sb.pop_front();
        chk("sum", sum, e[W-1:0]);
        chk("cout", cout, e[W]);
        chk("of", of, e[W+1]);
      end
    end
  end

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done after %0d cycles", lat);
    end
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                       input logic tc, input bit chk_lat);
    int lat, bc;
    @(negedge clk);
    a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
    sb.push_back(model(ta, tb_, ts, tc));
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc);
    if (chk_lat) begin
      chk("latency", lat, K);
      chk("busy_cycles", bc, K);
    end
  endtask

  initial begin
    int lat, bc, t1, t2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_of", of, 0);
    @(negedge clk) rst = 1'b0;

    do_op(32'h000000FF, 32'h00000001, 0, 0, 1);
    do_op(32'hFFFFFFFF, 32'h00000001, 0, 0, 1);
    do_op(32'h7FFFFFFF, 32'h00000001, 0, 0, 1);
    do_op(32'd5, 32'd7, 1, 1, 1);
    do_op(32'h80000000, 32'h00000001, 1, 0, 1);

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    a = 32'h12345678; b = 32'h11111111; sub = 0; cin = 1; start = 1'b1;
    sb.push_back(model(32'h12345678, 32'h11111111, 0, 1));
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    a = $urandom; b = $urandom; sub = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);

    // reset in the second RUN cycle aborts the op
    @(negedge clk);
    a = 32'hDEADBEEF; b = 32'h01020304; sub = 0; cin = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    chk("abort_of", of, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    do_op(32'd1, 32'd2, 0, 0, 1);

    // back-to-back: start held through DONE
    @(negedge clk);
    a = 32'd1; b = 32'd1; sub = 0; cin = 0; start = 1'b1;
    sb.push_back(model(32'd1, 32'd1, 0, 0));
    @(posedge clk); #1;
    wait_done(lat, bc);
    chk("b2b_lat1", lat, K);
    t1 = cyc;
    a = 32'd2; b = 32'd3;
    sb.push_back(model(32'd2, 32'd3, 0, 0));
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc);
    t2 = cyc;
    chk("b2b_gap", t2 - t1, K + 1);

    for (int i = 0; i < 40; i++) begin
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
